// File: rtl/factorial_seq_ctrl.sv
// Multi-cycle n! sequencer sharing one 32x4 multiplier across cycles.
// Define FACT_SATURATE_EN to clamp overflowing results to all-ones.
module factorial_seq_ctrl #(
  parameter int NUM_W = 4,
  parameter int RES_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] result,
  output logic             overflow
);

  localparam int PW = RES_W + NUM_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [RES_W-1:0]   acc_q, acc_d;
  logic [NUM_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic               oflag_q, oflag_d;
  logic [PW-1:0]      prod;
  logic [RES_W-1:0]   final_res;

  assign prod = {{NUM_W{1'b0}}, acc_q} * {{RES_W{1'b0}}, cnt_q};

`ifdef FACT_SATURATE_EN
  assign final_res = ovf_q ? {RES_W{1'b1}} : acc_q;
`else
  assign final_res = acc_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= RES_W'(1);
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
      oflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
      oflag_q <= oflag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    res_d   = res_q;
    oflag_d = oflag_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = RES_W'(1);
          cnt_d   = num;
          ovf_d   = 1'b0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (cnt_q > NUM_W'(1)) begin
          acc_d = prod[RES_W-1:0];
          ovf_d = ovf_q | (prod[PW-1:RES_W] != '0);
          cnt_d = cnt_q - NUM_W'(1);
        end else begin
          res_d   = final_res;
          oflag_d = ovf_q;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign result   = res_q;
  assign overflow = oflag_q;

endmodule

// File: tb/tb_factorial_seq_ctrl.sv
// Scoreboard bench for factorial_seq_ctrl against a plain-arithmetic n! model.
module tb_factorial_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  num = 4'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [32:0] sb[$];

  factorial_seq_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num      (num),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [32:0] model(input int n);
    longint unsigned f;
    logic ov;
    logic [31:0] r;
    f = 1;
    for (int i = 2; i <= n; i++) f = f * longint'(i);
    ov = (f > 64'hFFFF_FFFF);
    r = f[31:0];
`ifdef FACT_SATURATE_EN
    if (ov) r = 32'hFFFF_FFFF;
`endif
    return {ov, r};
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      logic [32:0] e;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: result %0d with no request pending", result);
      end else begin
        e = sb.pop_front();
        chk("result", longint'(result), longint'(e[31:0]));
        chk("overflow", longint'(overflow), longint'(e[32]));
        chk("busy_with_done", longint'(busy), 1);
      end
    end
  end

  task automatic wait_idle();
    int c;
    c = 0;
    @(posedge clk); #1;
    while (busy && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic run(input int n, input bit noise);
    int k;
    bit seen;
    int lat;
    wait_idle();
    sb.push_back(model(n));
    start = 1'b1;
    num = 4'(n);
    @(posedge clk); #1;
    start = 1'b0;
    num = 4'($urandom);
    chk("busy_after_start", longint'(busy), 1);
    k = 1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else begin
        if (noise) begin
          start = (k <= 3);
          num = 4'($urandom);
        end
        @(posedge clk);
        k++;
      end
    end
    start = 1'b0;
    lat = (n > 1) ? n : 1;
    chk("latency", seen ? k : -1, 1 + lat);
  endtask

  task automatic held_start();
    int e;
    int nd;
    int de[3];
    wait_idle();
    repeat (3) sb.push_back(model(3));
    start = 1'b1;
    num = 4'd3;
    e = 0;
    nd = 0;
    for (int i = 0; i < 60 && nd < 3; i++) begin
      @(posedge clk);
      e++;
      @(negedge clk);
      if (done) begin
        de[nd] = e;
        nd++;
        if (nd == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    chk("held_done_count", nd, 3);
    if (nd == 3) begin
      chk("held_first", de[0], 4);
      chk("held_gap1", de[1] - de[0], 5);
      chk("held_gap2", de[2] - de[1], 5);
    end
  endtask

  task automatic reset_mid();
    wait_idle();
    start = 1'b1;
    num = 4'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_result", longint'(result), 0);
    chk("rst_overflow", longint'(overflow), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
  endtask

  initial begin
    int dir[7] = '{0, 1, 5, 12, 13, 14, 15};
    #2;
    chk("reset_busy", longint'(busy), 0);
    chk("reset_done", longint'(done), 0);
    chk("reset_result", longint'(result), 0);
    chk("reset_overflow", longint'(overflow), 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    foreach (dir[i]) run(dir[i], 1'b0);
    run(7, 1'b1);
    held_start();
    reset_mid();
    run(4, 1'b0);
    for (int i = 0; i < 20; i++) run(int'($urandom_range(0, 15)), i[0]);
    wait_idle();
    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
